// File: rtl/uart_rx_cfg_if.sv
// uart_rx_cfg_if: serial line, received-character handshake and error pulses of uart_rx_cfg
interface uart_rx_cfg_if #(parameter int DATA_BITS = 9);
  logic rx;
  logic [DATA_BITS-1:0] data_out;
  logic parity_error;
  logic valid;
  logic ready;
  logic framing_error;
  logic overrun;
  logic busy;
  modport master(input rx, ready, output data_out, parity_error, valid, framing_error, overrun, busy);
  modport slave(output rx, ready, input data_out, parity_error, valid, framing_error, overrun, busy);
endinterface

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised oversampling UART receiver with 3-sample majority vote and receive FIFO
module uart_rx_cfg #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 9,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic clock,
  input logic reset,
  uart_rx_cfg_if.master u
);
  localparam int DIV_RAW = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV = DIV_RAW < 1 ? 1 : DIV_RAW;
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PAR = 3'd3, STOP = 3'd4, ERR_WAIT = 3'd5;
  logic rx_m, rx_s;
  logic [DW-1:0] dc;
  logic [SW-1:0] sc;
  logic [1:0] v;
  logic [2:0] state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0] bc;
  logic perr, stop2, fe, ov;
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic tick, start_edge, decide, wrap, maj, last_stop, push, pop, full, wr;
  assign tick = dc == DW'(DIV - 1);
  assign start_edge = state == IDLE && !rx_s;
  assign decide = tick && sc == SW'(OVERSAMPLE / 2 + 1);
  assign wrap = tick && sc == SW'(OVERSAMPLE - 1);
  assign maj = (v[0] & v[1]) | (v[0] & rx_s) | (v[1] & rx_s);
  assign last_stop = STOP_BITS == 1 || stop2;
  assign push = state == STOP && decide && maj && last_stop;
  assign pop = u.valid && u.ready;
  assign full = cnt == CW'(FIFO_DEPTH);
  assign wr = push && (!full || pop);
  // the divider and sample counter restart on the start edge so votes land mid-bit
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      dc <= '0;
      sc <= '0;
      v <= '0;
    end else begin
      rx_m <= u.rx;
      rx_s <= rx_m;
      dc <= start_edge || tick ? '0 : dc + 1'b1;
      sc <= start_edge ? '0 : !tick ? sc : wrap ? '0 : sc + 1'b1;
      if (tick && sc == SW'(OVERSAMPLE / 2 - 1)) v[0] <= rx_s;
      if (tick && sc == SW'(OVERSAMPLE / 2)) v[1] <= rx_s;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bc <= '0;
      perr <= 1'b0;
      stop2 <= 1'b0;
      fe <= 1'b0;
    end else begin
      fe <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          bc <= '0;
          perr <= 1'b0;
          stop2 <= 1'b0;
        end
        START: if (decide && maj) state <= IDLE; else if (wrap) state <= DATA;
        DATA: begin
          if (decide) begin
            shreg <= {maj, shreg[DATA_BITS-1:1]};
            bc <= bc + 1'b1;
          end
          if (wrap && bc == 4'(DATA_BITS)) state <= PARITY != 0 ? PAR : STOP;
        end
        PAR: begin
          if (decide) perr <= ^{shreg, maj} ^ (PARITY == 1);
          if (wrap) state <= STOP;
        end
        // the final good stop returns to IDLE at once so a back-to-back start is caught
        STOP: if (decide) begin
          if (!maj) begin
            state <= ERR_WAIT;
            fe <= 1'b1;
          end else if (last_stop) state <= IDLE;
          else stop2 <= 1'b1;
        end
        ERR_WAIT: if (tick && rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ov <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      ov <= push && full && !pop;
      if (wr) begin
        mem[wp] <= {perr, shreg};
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(wr) - CW'(pop);
    end
  end
  assign u.data_out = mem[rp][DATA_BITS-1:0];
  assign u.parity_error = mem[rp][DATA_BITS];
  assign u.valid = cnt != '0;
  assign u.framing_error = fe;
  assign u.overrun = ov;
  assign u.busy = state != IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: two receiver configurations (9N1 and 8E2) driven by table, directed and random frames
module tb_uart_rx_cfg;
  localparam int BIT = 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  logic rx_l [2];
  logic rdy [2];
  uart_rx_cfg_if #(.DATA_BITS(9)) ua();
  uart_rx_cfg_if #(.DATA_BITS(8)) ub();
  assign ua.rx = rx_l[0];
  assign ua.ready = rdy[0];
  assign ub.rx = rx_l[1];
  assign ub.ready = rdy[1];
  uart_rx_cfg #(.CLK_HZ(640_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clock(clock), .reset(reset), .u(ua));
  uart_rx_cfg #(.CLK_HZ(640_000), .BAUD_RATE(10_000), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.clock(clock), .reset(reset), .u(ub));
  int checks = 0, errors = 0;
  logic [9:0] got_a [$];
  logic [9:0] got_b [$];
  int fe_cnt [2];
  int ov_cnt [2];
  always @(negedge clock) begin
    #2;
    if (ua.valid && ua.ready) got_a.push_back({ua.parity_error, ua.data_out});
    if (ub.valid && ub.ready) got_b.push_back({ub.parity_error, 1'b0, ub.data_out});
    fe_cnt[0] += int'(ua.framing_error);
    fe_cnt[1] += int'(ub.framing_error);
    ov_cnt[0] += int'(ua.overrun);
    ov_cnt[1] += int'(ub.overrun);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic hold(input int p, input logic val, input int n);
    rx_l[p] = val;
    repeat (n) @(negedge clock);
  endtask
  // port 0: 9 data, no parity, 1 stop; port 1: 8 data, parity bit pb, 2 stops
  task automatic send(input int p, input logic [8:0] d, input int pb, input bit sbad, input int gl);
    int nb;
    nb = p ? 8 : 9;
    hold(p, 1'b0, BIT);
    for (int i = 0; i < nb; i++)
      if (i == gl) begin
        hold(p, d[i], 30);
        hold(p, !d[i], 4);
        hold(p, d[i], 30);
      end else hold(p, d[i], BIT);
    if (p == 1) hold(p, pb[0], BIT);
    for (int s = 0; s < (p ? 2 : 1); s++) hold(p, !sbad, BIT);
    if (sbad) hold(p, 1'b1, 16);
  endtask
  task automatic take(input int p, output bit ok, output logic [9:0] val);
    val = '0;
    ok = 1'b0;
    if (p == 0 && got_a.size() > 0) begin
      ok = 1'b1;
      val = got_a.pop_front();
    end
    if (p == 1 && got_b.size() > 0) begin
      ok = 1'b1;
      val = got_b.pop_front();
    end
  endtask
  task automatic expect_frame(input int p, input logic [8:0] ed, input bit ep, input bit efe, input int fe0, input string tag);
    bit ok;
    logic [9:0] val;
    chk({tag, " fe"}, fe_cnt[p] - fe0, 32'(efe));
    take(p, ok, val);
    chk({tag, " got"}, 32'(ok), 32'(!efe));
    if (ok) begin
      chk({tag, " data"}, 32'(val[8:0]), 32'(ed));
      chk({tag, " perr"}, 32'(val[9]), 32'(ep));
    end
  endtask
  typedef struct {
    int p;
    logic [8:0] d;
    int pb;
    bit sbad;
    int gl;
    logic [8:0] ed;
    bit ep;
    bit efe;
  } vec_t;
  vec_t tbl [12];
  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin : main
    int fe0, ov0, p, pb, gl;
    bit sbad, ok, ep;
    logic [8:0] d;
    logic [9:0] val;
    tbl[0]  = '{0, 9'h1A5, 0, 1'b0, -1, 9'h1A5, 1'b0, 1'b0};
    tbl[1]  = '{0, 9'h000, 0, 1'b0, -1, 9'h000, 1'b0, 1'b0};
    tbl[2]  = '{0, 9'h1FF, 0, 1'b0, -1, 9'h1FF, 1'b0, 1'b0};
    tbl[3]  = '{0, 9'h0F0, 0, 1'b0, 4, 9'h0F0, 1'b0, 1'b0};
    tbl[4]  = '{0, 9'h0FF, 0, 1'b1, -1, 9'h000, 1'b0, 1'b1};
    tbl[5]  = '{1, 9'h007, 1, 1'b0, -1, 9'h007, 1'b0, 1'b0};
    tbl[6]  = '{1, 9'h007, 0, 1'b0, -1, 9'h007, 1'b1, 1'b0};
    tbl[7]  = '{1, 9'h0A5, 0, 1'b0, -1, 9'h0A5, 1'b0, 1'b0};
    tbl[8]  = '{1, 9'h080, 0, 1'b0, -1, 9'h080, 1'b1, 1'b0};
    tbl[9]  = '{1, 9'h05A, 0, 1'b0, 1, 9'h05A, 1'b0, 1'b0};
    tbl[10] = '{1, 9'h03C, 0, 1'b1, -1, 9'h000, 1'b0, 1'b1};
    tbl[11] = '{1, 9'h0FF, 1, 1'b0, -1, 9'h0FF, 1'b1, 1'b0};
    rx_l[0] = 1'b1;
    rx_l[1] = 1'b1;
    rdy[0] = 1'b1;
    rdy[1] = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst valid", {ua.valid, ub.valid}, 0);
    chk("rst data", {ua.data_out, ub.data_out}, 0);
    chk("rst perr", {ua.parity_error, ub.parity_error}, 0);
    chk("rst pulses", {ua.framing_error, ua.overrun, ub.framing_error, ub.overrun}, 0);
    chk("rst busy", {ua.busy, ub.busy}, 0);
    reset = 1'b0;
    hold(0, 1'b1, 20);
    foreach (tbl[i]) begin
      fe0 = fe_cnt[tbl[i].p];
      send(tbl[i].p, tbl[i].d, tbl[i].pb, tbl[i].sbad, tbl[i].gl);
      hold(tbl[i].p, 1'b1, 8);
      expect_frame(tbl[i].p, tbl[i].ed, tbl[i].ep, tbl[i].efe, fe0, $sformatf("vec%0d", i));
    end
    fe0 = fe_cnt[0];
    hold(0, 1'b0, 20);
    chk("glitch busy in start", 32'(ua.busy), 1);
    hold(0, 1'b1, 30);
    chk("glitch busy after", 32'(ua.busy), 0);
    chk("glitch no frame", got_a.size(), 0);
    chk("glitch no fe", fe_cnt[0] - fe0, 0);
    fe0 = fe_cnt[0];
    hold(0, 1'b0, BIT * 31);
    chk("break busy", 32'(ua.busy), 1);
    hold(0, 1'b1, BIT);
    chk("break busy released", 32'(ua.busy), 0);
    expect_frame(0, 9'h0, 1'b0, 1'b1, fe0, "break");
    fe0 = fe_cnt[0];
    send(0, 9'h03C, 0, 1'b0, -1);
    hold(0, 1'b1, 8);
    expect_frame(0, 9'h03C, 1'b0, 1'b0, fe0, "after break");
    rdy[0] = 1'b0;
    ov0 = ov_cnt[0];
    for (int k = 1; k <= 5; k++) send(0, 9'(k), 0, 1'b0, -1);
    hold(0, 1'b1, 8);
    chk("ovr pulses", ov_cnt[0] - ov0, 1);
    chk("ovr valid held", 32'(ua.valid), 1);
    rdy[0] = 1'b1;
    hold(0, 1'b1, 10);
    chk("ovr drained count", got_a.size(), 4);
    for (int k = 1; k <= 4; k++) begin
      take(0, ok, val);
      chk($sformatf("ovr drain %0d", k), 32'(val), 32'(k));
    end
    rdy[0] = 1'b0;
    ov0 = ov_cnt[0];
    for (int k = 1; k <= 4; k++) send(0, 9'(k), 0, 1'b0, -1);
    fork
      send(0, 9'd5, 0, 1'b0, -1);
      begin
        repeat (682) @(negedge clock);
        rdy[0] = 1'b1;
        @(negedge clock);
        rdy[0] = 1'b0;
      end
    join
    hold(0, 1'b1, 8);
    chk("full pop no ovr", ov_cnt[0] - ov0, 0);
    chk("full pop popped", got_a.size(), 1);
    take(0, ok, val);
    chk("full pop head", 32'(val), 1);
    rdy[0] = 1'b1;
    hold(0, 1'b1, 10);
    chk("full pop remain", got_a.size(), 4);
    for (int k = 2; k <= 5; k++) begin
      take(0, ok, val);
      chk($sformatf("full pop drain %0d", k), 32'(val), 32'(k));
    end
    rdy[1] = 1'b0;
    send(1, 9'h011, 0, 1'b0, -1);
    hold(1, 1'b1, 8);
    chk("pre-reset valid", 32'(ub.valid), 1);
    hold(1, 1'b0, BIT);
    hold(1, 1'b1, BIT);
    hold(1, 1'b0, 30);
    chk("pre-reset busy", 32'(ub.busy), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid reset valid", 32'(ub.valid), 0);
    chk("mid reset data", 32'(ub.data_out), 0);
    chk("mid reset busy", 32'(ub.busy), 0);
    chk("mid reset perr", 32'(ub.parity_error), 0);
    reset = 1'b0;
    rdy[1] = 1'b1;
    hold(1, 1'b1, 100);
    fe0 = fe_cnt[1];
    send(1, 9'h0C3, 0, 1'b0, -1);
    send(1, 9'h05E, 1, 1'b0, -1);
    hold(1, 1'b1, 8);
    chk("b2b count", got_b.size(), 2);
    expect_frame(1, 9'h0C3, 1'b0, 1'b0, fe0, "b2b first");
    expect_frame(1, 9'h05E, 1'b0, 1'b0, fe0, "b2b second");
    for (int n = 0; n < 24; n++) begin
      p = n % 2;
      d = 9'($urandom);
      if (p == 1) d[8] = 1'b0;
      pb = int'($urandom_range(0, 1));
      sbad = $urandom_range(0, 5) == 0;
      gl = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, p ? 7 : 8)) : -1;
      ep = p == 1 && (($countones(d) + pb) % 2 != 0);
      fe0 = fe_cnt[p];
      send(p, d, pb, sbad, gl);
      hold(p, 1'b1, 8 + int'($urandom_range(0, 40)));
      expect_frame(p, d, ep, sbad, fe0, $sformatf("rand%0d", n));
    end
    chk("rand no overrun", ov_cnt[0] + ov_cnt[1] - 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
